// File: rtl/mem_responder.sv
// mem_responder: single-outstanding, word-organised, byte-writable memory
// responder for the multicycle RV32I core. It accepts one read or write, waits
// a fixed number of cycles and returns a one-cycle mem_resp with read data.
//
// Optional feature macro: MEM_RESPONDER_PROTO_CHECK_EN
//   defined   -> proto_err is a sticky flag for handshake violations
//   undefined -> proto_err is tied low and no checking logic is built
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  // Wait-counter start value; only meaningful when LATENCY >= 2.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic             DIRECT_RESP = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  // Latched copy of the accepted request
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  is_read_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_W-1:0]     wdata_q;

  logic                  accept_c;
  logic                  commit_c;
  logic                  req_c;
  logic [ADDR_WIDTH-1:0] in_idx_c;

  // Operation seen by the commit edge (live inputs when committing from IDLE)
  logic [ADDR_WIDTH-1:0] cur_idx_c;
  logic                  cur_read_c;
  logic [BE_W-1:0]       cur_be_c;
  logic [DATA_W-1:0]     cur_wdata_c;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  // Byte offset and aliased upper address bits carry no meaning here
  logic                  unused_addr_c;

  assign req_c         = mem_read | mem_write;
  assign in_idx_c      = mem_address[ADDR_WIDTH+1:2];
  assign unused_addr_c = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, acceptance and commit strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          accept_c = 1'b1;
          if (DIRECT_RESP) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    commit_c = (state_d == RESP) && (state_q != RESP);
  end

  // Select live request fields in IDLE, latched copies otherwise
  always_comb begin
    cur_idx_c   = idx_q;
    cur_read_c  = is_read_q;
    cur_be_c    = be_q;
    cur_wdata_c = wdata_q;
    if (state_q == IDLE) begin
      cur_idx_c   = in_idx_c;
      cur_read_c  = mem_read;
      cur_be_c    = mem_byte_enable;
      cur_wdata_c = mem_wdata;
    end
  end

  // Capture the request at acceptance; read wins over a simultaneous write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      is_read_q <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else if (accept_c) begin
      idx_q     <= in_idx_c;
      is_read_q <= mem_read;
      be_q      <= mem_byte_enable;
      wdata_q   <= mem_wdata;
    end
  end

  // Storage write on the edge into RESP; held off while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && commit_c && !cur_read_c) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (cur_be_c[i]) begin
          mem_q[cur_idx_c][i*LANE_W +: LANE_W] <= cur_wdata_c[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Response pulse and read data; rdata only changes when a read completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= (state_d == RESP);
      if (commit_c && cur_read_c) begin
        mem_rdata <= mem_q[cur_idx_c];
      end
    end
  end

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  logic [31:0] chk_addr_q;
  logic        chk_read_q;
  logic        chk_write_q;
  logic        viol_c;

  // Raw request signals as seen at acceptance, for BUSY-phase stability checks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_addr_q  <= '0;
      chk_read_q  <= 1'b0;
      chk_write_q <= 1'b0;
    end else if (accept_c) begin
      chk_addr_q  <= mem_address;
      chk_read_q  <= mem_read;
      chk_write_q <= mem_write;
    end
  end

  // Violation: dual request at acceptance, or request dropped/changed in BUSY
  always_comb begin
    viol_c = 1'b0;
    if (accept_c && mem_read && mem_write) begin
      viol_c = 1'b1;
    end
    if (state_q == BUSY) begin
      if (!req_c || (mem_address != chk_addr_q) ||
          (mem_read != chk_read_q) || (mem_write != chk_write_q)) begin
        viol_c = 1'b1;
      end
    end
  end

  // Sticky flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proto_err <= 1'b0;
    end else if (viol_c) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule
